// File: rtl/cpu6_trap_ctrl_pkg.sv
// cpu6_trap_ctrl_pkg
// Shared definitions for the cpu6 trap sequencer:
//   - CPU6_XLEN              : default datapath / CSR width
//   - CPU6_MCAUSE_MEI        : exception code of the machine external interrupt
//   - CPU6_MCAUSE_INT_BIT    : mcause bit that marks an interrupt cause
//   - trap_state_e           : sequencer states (3-bit encoding)
//   - trap_kind_e            : what the running sequence will do after FLUSH
package cpu6_trap_ctrl_pkg;

  localparam int CPU6_XLEN           = 32;
  localparam int CPU6_MCAUSE_MEI     = 11;
  localparam int CPU6_MCAUSE_INT_BIT = CPU6_XLEN - 1;

  typedef enum logic [2:0] {
    CPU6_TRAP_IDLE  = 3'd0,
    CPU6_TRAP_FLUSH = 3'd1,
    CPU6_TRAP_SAVE  = 3'd2,
    CPU6_TRAP_RET   = 3'd3,
    CPU6_TRAP_REDIR = 3'd4
  } trap_state_e;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } trap_kind_e;

endpackage

// File: rtl/cpu6_trap_ctrl_if.sv
// cpu6_trap_ctrl_if
// Bundles every signal between the trap sequencer and its neighbours
// (stage-M detect, CSR unit, fetch PC mux).
//   slave  : the trap sequencer (takes requests, drives CSR/redirect outputs)
//   master : the core side (raises requests, consumes CSR/redirect outputs)
interface cpu6_trap_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 4
);
  logic               excp_valid;
  logic [XLEN-1:0]    excp_pc;
  logic [CAUSE_W-1:0] excp_code;
  logic               irq_pending;
  logic               mret_valid;
  logic               mstatus_mie;
  logic [XLEN-1:0]    mtvec_in;
  logic [XLEN-1:0]    mepc_in;
  logic               redirect_ready;
  logic               busy;
  logic               flush;
  logic               csr_trap_we;
  logic [XLEN-1:0]    csr_mepc_wdata;
  logic [XLEN-1:0]    csr_mcause_wdata;
  logic               mstatus_trap;
  logic               mstatus_mret;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;

  modport slave (
    input  excp_valid, excp_pc, excp_code, irq_pending, mret_valid,
           mstatus_mie, mtvec_in, mepc_in, redirect_ready,
    output busy, flush, csr_trap_we, csr_mepc_wdata, csr_mcause_wdata,
           mstatus_trap, mstatus_mret, redirect_valid, redirect_pc
  );

  modport master (
    output excp_valid, excp_pc, excp_code, irq_pending, mret_valid,
           mstatus_mie, mtvec_in, mepc_in, redirect_ready,
    input  busy, flush, csr_trap_we, csr_mepc_wdata, csr_mcause_wdata,
           mstatus_trap, mstatus_mret, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cpu6_trap_ctrl.sv
// cpu6_trap_ctrl
// Trap sequencer: every exception, enabled machine interrupt and MRET runs
// IDLE -> FLUSH (FLUSH_CYCLES) -> SAVE or RET (1) -> REDIR (until ready).
// Sole owner of the CSR trap-write ports. All outputs are registered and are
// decoded from the next state, so they line up with the state they describe.
// Ports:
//   clk    : core clock
//   reset  : asynchronous active-low reset
//   bus    : cpu6_trap_ctrl_if.slave (requests in, CSR/flush/redirect out)
module cpu6_trap_ctrl
  import cpu6_trap_ctrl_pkg::*;
#(
  parameter int XLEN         = CPU6_XLEN,
  parameter int CAUSE_W      = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  cpu6_trap_ctrl_if.slave  bus
);

  localparam logic [2:0]      FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] MCAUSE_IRQ =
    {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, CAUSE_W'(CPU6_MCAUSE_MEI)};

  trap_state_e     state_r, state_s;
  trap_kind_e      kind_r, kind_s;
  logic [2:0]      cnt_r, cnt_s;
  logic [XLEN-1:0] pc_r, pc_s;
  logic [XLEN-1:0] cause_r, cause_s;
  logic [XLEN-1:0] rpc_r, rpc_s;

  logic            busy_r, flush_r, we_r, trap_r, mret_r, rvalid_r;
  logic [XLEN-1:0] mepc_wdata_r, mcause_wdata_r;

  // Next-state logic; request inputs only matter while IDLE.
  always_comb begin
    state_s = state_r;
    kind_s  = kind_r;
    cnt_s   = cnt_r;
    pc_s    = pc_r;
    cause_s = cause_r;
    rpc_s   = rpc_r;
    case (state_r)
      CPU6_TRAP_IDLE: begin
        if (bus.excp_valid) begin
          pc_s    = bus.excp_pc;
          cause_s = XLEN'(bus.excp_code);
          kind_s  = KIND_TRAP;
          cnt_s   = FLUSH_LOAD;
          state_s = CPU6_TRAP_FLUSH;
        end else if (bus.irq_pending && bus.mstatus_mie) begin
          pc_s    = bus.excp_pc;
          cause_s = MCAUSE_IRQ;
          kind_s  = KIND_TRAP;
          cnt_s   = FLUSH_LOAD;
          state_s = CPU6_TRAP_FLUSH;
        end else if (bus.mret_valid) begin
          kind_s  = KIND_MRET;
          cnt_s   = FLUSH_LOAD;
          state_s = CPU6_TRAP_FLUSH;
        end else begin
          state_s = CPU6_TRAP_IDLE;
        end
      end
      CPU6_TRAP_FLUSH: begin
        if (cnt_r == 3'd0) begin
          state_s = (kind_r == KIND_TRAP) ? CPU6_TRAP_SAVE : CPU6_TRAP_RET;
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      CPU6_TRAP_SAVE: begin
        // Direct mode only: mtvec MODE bits are dropped.
        rpc_s   = {bus.mtvec_in[XLEN-1:2], 2'b00};
        state_s = CPU6_TRAP_REDIR;
      end
      CPU6_TRAP_RET: begin
        rpc_s   = {bus.mepc_in[XLEN-1:1], 1'b0};
        state_s = CPU6_TRAP_REDIR;
      end
      CPU6_TRAP_REDIR: begin
        if (bus.redirect_ready) begin
          state_s = CPU6_TRAP_IDLE;
        end else begin
          state_s = CPU6_TRAP_REDIR;
        end
      end
      default: begin
        state_s = CPU6_TRAP_IDLE;
      end
    endcase
  end

  // Sequencer state, flush counter and captured trap context.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= CPU6_TRAP_IDLE;
      kind_r  <= KIND_TRAP;
      cnt_r   <= 3'd0;
      pc_r    <= {XLEN{1'b0}};
      cause_r <= {XLEN{1'b0}};
      rpc_r   <= {XLEN{1'b0}};
    end else begin
      state_r <= state_s;
      kind_r  <= kind_s;
      cnt_r   <= cnt_s;
      pc_r    <= pc_s;
      cause_r <= cause_s;
      rpc_r   <= rpc_s;
    end
  end

  // Output registers decoded from the next state so they are glitch-free and
  // cleared immediately by reset, killing any pending CSR write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r         <= 1'b0;
      flush_r        <= 1'b0;
      we_r           <= 1'b0;
      trap_r         <= 1'b0;
      mret_r         <= 1'b0;
      rvalid_r       <= 1'b0;
      mepc_wdata_r   <= {XLEN{1'b0}};
      mcause_wdata_r <= {XLEN{1'b0}};
    end else begin
      busy_r         <= (state_s != CPU6_TRAP_IDLE);
      flush_r        <= (state_s == CPU6_TRAP_FLUSH);
      we_r           <= (state_s == CPU6_TRAP_SAVE);
      trap_r         <= (state_s == CPU6_TRAP_SAVE);
      mret_r         <= (state_s == CPU6_TRAP_RET);
      rvalid_r       <= (state_s == CPU6_TRAP_REDIR);
      mepc_wdata_r   <= (state_s == CPU6_TRAP_SAVE) ? {pc_s[XLEN-1:1], 1'b0}
                                                    : {XLEN{1'b0}};
      mcause_wdata_r <= (state_s == CPU6_TRAP_SAVE) ? cause_s : {XLEN{1'b0}};
    end
  end

  assign bus.busy             = busy_r;
  assign bus.flush            = flush_r;
  assign bus.csr_trap_we      = we_r;
  assign bus.csr_mepc_wdata   = mepc_wdata_r;
  assign bus.csr_mcause_wdata = mcause_wdata_r;
  assign bus.mstatus_trap     = trap_r;
  assign bus.mstatus_mret     = mret_r;
  assign bus.redirect_valid   = rvalid_r;
  assign bus.redirect_pc      = rpc_r;

endmodule
